// File: rtl/ysyx_22041412_mem_arbiter.sv
// Two-master read arbiter: IF and LS share one downstream read port, one
// transaction at a time, round-robin on ties, IF flush and timeout abort.
module ysyx_22041412_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_i,
  input  logic [31:0] if_addr_i,
  input  logic [7:0]  if_size_i,
  output logic        if_ready_o,
  output logic [63:0] if_data_o,
  input  logic        ls_valid_i,
  input  logic [31:0] ls_addr_i,
  input  logic [7:0]  ls_size_i,
  output logic        ls_ready_o,
  output logic [63:0] ls_data_o,
  input  logic        flush_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_size_o,
  input  logic        mem_ready_i,
  input  logic [63:0] mem_data_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester holds *_valid_i (with stable addr/size) until its
  // one-cycle *_ready_o pulse; mem_valid_o is held (addr/size stable) until a
  // one-cycle mem_ready_i or the timeout abort. mem_ready_i outside BUSY is ignored.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_LS = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_ls;
  logic        w_last_ls_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_mem_valid;
  logic        w_mem_valid_nxt;
  logic [31:0] r_mem_addr;
  logic [31:0] w_mem_addr_nxt;
  logic [7:0]  r_mem_size;
  logic [7:0]  w_mem_size_nxt;
  logic        r_if_ready;
  logic        w_if_ready_nxt;
  logic [63:0] r_if_data;
  logic [63:0] w_if_data_nxt;
  logic        r_ls_ready;
  logic        w_ls_ready_nxt;
  logic [63:0] r_ls_data;
  logic [63:0] w_ls_data_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_if_req;
  logic        w_grant_ls;
  logic        w_finish;
  logic        w_drop_eff;
  logic [63:0] w_resp_data;

  // A flushed IF request never qualifies; LS wins a tie when IF went last.
  assign w_if_req    = if_valid_i & ~flush_i;
  assign w_grant_ls  = ls_valid_i & (~w_if_req | ~r_last_ls);
  assign w_finish    = mem_ready_i | (r_cnt == CNT_LAST);
  assign w_drop_eff  = r_drop | flush_i;
  assign w_resp_data = mem_ready_i ? mem_data_i : 64'd0;

  always_comb begin
    w_state_nxt     = r_state;
    w_last_ls_nxt   = r_last_ls;
    w_drop_nxt      = r_drop;
    w_cnt_nxt       = r_cnt;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_size_nxt  = r_mem_size;
    w_if_ready_nxt  = 1'b0;
    w_if_data_nxt   = r_if_data;
    w_ls_ready_nxt  = 1'b0;
    w_ls_data_nxt   = r_ls_data;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_if_req || ls_valid_i) begin
          w_mem_valid_nxt = 1'b1;
          w_cnt_nxt       = 16'd0;
          w_drop_nxt      = 1'b0;
          w_last_ls_nxt   = w_grant_ls;
          if (w_grant_ls) begin
            w_mem_addr_nxt = ls_addr_i;
            w_mem_size_nxt = ls_size_i;
            w_state_nxt    = S_BUSY_LS;
          end else begin
            w_mem_addr_nxt = if_addr_i;
            w_mem_size_nxt = if_size_i;
            w_state_nxt    = S_BUSY_IF;
          end
        end
      end
      S_BUSY_IF, S_BUSY_LS: begin
        if (w_finish) begin
          // A response on the timeout edge wins, so err only fires without one.
          w_mem_valid_nxt = 1'b0;
          w_state_nxt     = S_DONE;
          w_drop_nxt      = 1'b0;
          w_err_nxt       = ~mem_ready_i;
          if (r_state == S_BUSY_LS) begin
            w_ls_ready_nxt = 1'b1;
            w_ls_data_nxt  = w_resp_data;
          end else if (!w_drop_eff) begin
            w_if_ready_nxt = 1'b1;
            w_if_data_nxt  = w_resp_data;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_state == S_BUSY_IF && flush_i) begin
            w_drop_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last_ls   <= 1'b0;
      r_drop      <= 1'b0;
      r_cnt       <= 16'd0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_size  <= 8'd0;
      r_if_ready  <= 1'b0;
      r_if_data   <= 64'd0;
      r_ls_ready  <= 1'b0;
      r_ls_data   <= 64'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_ls   <= w_last_ls_nxt;
      r_drop      <= w_drop_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_size  <= w_mem_size_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_if_data   <= w_if_data_nxt;
      r_ls_ready  <= w_ls_ready_nxt;
      r_ls_data   <= w_ls_data_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign if_ready_o  = r_if_ready;
  assign if_data_o   = r_if_data;
  assign ls_ready_o  = r_ls_ready;
  assign ls_data_o   = r_ls_data;
  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_mem_addr;
  assign mem_size_o  = r_mem_size;
  assign err_o       = r_err;
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: doc/ysyx_22041412_mem_arbiter.md
# ysyx_22041412_mem_arbiter

Two-master arbiter that shares the core's single AXI-style read port between the instruction fetch stage (IF) and the load/store stage (LS). It sits between the fetch/LSU request logic and the bus bridge:
- grants one outstanding read at a time, with round-robin on ties;
- drives the downstream valid/address/size and routes the returned data back to the owner;
- cancels in-flight instruction fetches on a redirect;
- aborts transactions that exceed a timeout.

## Interface
- TIMEOUT, 255, cycles a granted request may wait for mem_ready_i before abort (1..65535)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_valid_i  in  1  IF read request; held high until if_ready_o pulse
- if_addr_i  in  32  IF read address
- if_size_i  in  8  IF byte-strobe/size code
- if_ready_o  out  1  one-cycle response pulse to IF
- if_data_o  out  64  IF response data, valid while if_ready_o=1
- ls_valid_i, ls_addr_i, ls_size_i  in  1/32/8  LS request, same rules as IF
- ls_ready_o  out  1  one-cycle response pulse to LS
- ls_data_o  out  64  LS response data
- flush_i  in  1  control-flow redirect; cancels pending or in-flight IF request
- mem_valid_o  out  1  downstream read request, held until mem_ready_i
- mem_addr_o  out  32  downstream address
- mem_size_o  out  8  downstream size
- mem_ready_i  in  1  downstream response valid (one cycle)
- mem_data_i  in  64  downstream response data
- busy_o  out  1  1 in any state other than IDLE
- err_o  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, BUSY_IF, BUSY_LS, DONE.
- IDLE → BUSY_xx:
  - on the first edge with a qualifying request, register mem_valid_o=1 and mem_addr_o/mem_size_o from the winner.
  - IF qualifies only if if_valid_i=1 and flush_i=0.
- Tie rule (both qualify): grant the requester not granted most recently.
  - last_grant resets to IF, so LS wins the first tie.
  - last_grant updates on every grant.
- BUSY_xx with mem_ready_i=1:
  - mem_valid_o←0.
  - Owner's data←mem_data_i and owner's ready←1, unless the IF drop flag is set.
  - Next state DONE.
- DONE:
  - Ready pulses drop to 0.
  - No grant is issued, because the requester is still deasserting valid.
  - Next state is always IDLE.
- Flush:
  - flush_i=1 in BUSY_IF sets the drop flag.
  - With the drop flag set, the IF response is consumed from the bus but if_ready_o stays 0 and if_data_o is unchanged.
  - The drop flag clears on entering DONE.
  - flush_i in BUSY_LS has no effect.
- Timeout:
  - A wait counter clears on grant and increments each BUSY cycle with mem_ready_i=0.
  - When the count reaches TIMEOUT-1 without a response: mem_valid_o←0, err_o←1 for one cycle, owner ready←1 with data 0 (IF: suppressed if the drop flag is set), next state DONE.
  - If mem_ready_i arrives on the same edge as the timeout, the response wins and err_o stays 0.
- mem_addr_o/mem_size_o hold their values through BUSY; they are don't-care otherwise but must not change while mem_valid_o=1.
- Reset values: mem_valid_o=0, mem_addr_o=0, mem_size_o=0, if_ready_o=0, ls_ready_o=0, if_data_o=0, ls_data_o=0, err_o=0, busy_o=0, state IDLE, drop flag 0, counter 0.
- Asserting reset mid-transaction:
  - returns all outputs to reset values immediately;
  - any later mem_ready_i in IDLE is ignored.
- mem_ready_i in IDLE or DONE is ignored.

## Timing
- Request seen in cycle N (IDLE) → mem_valid_o=1 in cycle N+1.
- mem_ready_i=1 in cycle M → requester ready=1 with data in cycle M+1, mem_valid_o=0 in M+1.
- Earliest next mem_valid_o is M+3 (M+1 DONE, M+2 IDLE evaluates).
- Minimum back-to-back turnaround is therefore 3 cycles between responses with a 1-cycle bus.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single IF read at 0x80000000, size 0x0F, bus replies after 2 cycles with 0x00000013_00100093:
  - mem_valid_o rises at N+1;
  - if_ready_o pulses one cycle with that data;
  - ls_ready_o stays 0.
- IF and LS valid in the same cycle right after reset, LS addr 0x80001000: LS is granted first; IF is granted at the next IDLE; the third tie goes to LS.
- Flush during BUSY_IF:
  - mem_valid_o stays high until the bus response;
  - if_ready_o never pulses for that request;
  - the next IF request at 0x80000100 completes normally.
- TIMEOUT=4, bus never responds: mem_valid_o drops after 4 BUSY cycles, err_o pulses once, ls_ready_o pulses with data 0.
- mem_ready_i coincident with the timeout edge: data is delivered, err_o=0.
- Reset (rst=0) asserted mid-BUSY_LS: outputs are 0 immediately; a stray mem_ready_i after release produces no ready pulse.
